// File: rtl/dec_bcd_pkg.sv
// Shared widths, limits and types for the BCD to decimal decoder slice.
// Optional feature macro used by this slice: DEC_BCD_TO_DEC_ERR_EN.
package dec_bcd_pkg;

    localparam int unsigned NUM_DEC_OUT = 10;
    localparam int unsigned BCD_W       = 4;
    localparam int unsigned BCD_MAX     = 9;

    typedef logic [BCD_W-1:0]       bcd_t;
    typedef logic [NUM_DEC_OUT-1:0] dec_hot_t;

endpackage

// File: rtl/dec_bcd_core.sv
// Combinational BCD decode: one-hot decimal vector plus an invalid-code flag.
module dec_bcd_core
    import dec_bcd_pkg::*;
(
    input  logic     en,
    input  bcd_t     code,
    output dec_hot_t hot,
    output logic     invalid
);

    // Decode a valid digit to one line; codes above 9 light nothing and flag invalid when enabled.
    always_comb begin
        hot     = '0;
        invalid = 1'b0;
        if (code > bcd_t'(BCD_MAX)) begin
            invalid = en;
        end else if (en) begin
            hot = dec_hot_t'(1) << code;
        end
    end

endmodule

// File: rtl/dec_bcd_to_dec.sv
// Registered 4-bit BCD to 1-of-10 decimal decoder with enable.
// Defining DEC_BCD_TO_DEC_ERR_EN adds a registered active-high err output
// flagging enabled codes 10-15.
module dec_bcd_to_dec
    import dec_bcd_pkg::*;
#(
    parameter bit OUT_ACTIVE_LOW = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic E,
    input  logic A,
    input  logic B,
    input  logic C,
    input  logic D,
    output logic D0,
    output logic D1,
    output logic D2,
    output logic D3,
    output logic D4,
    output logic D5,
    output logic D6,
    output logic D7,
    output logic D8,
    output logic D9
`ifdef DEC_BCD_TO_DEC_ERR_EN
    ,
    output logic err
`endif
);

    bcd_t     code;
    dec_hot_t hot;
    dec_hot_t hot_q;
    dec_hot_t dec_out;
    logic     invalid;

    assign code = {A, B, C, D};

    dec_bcd_core u_core (
        .en      (E),
        .code    (code),
        .hot     (hot),
        .invalid (invalid)
    );

    // Output register holds the active-high one-hot; async reset clears it to all-off.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hot_q <= '0;
        end else begin
            hot_q <= hot;
        end
    end

    // Polarity is applied after the register so reset and idle follow OUT_ACTIVE_LOW too.
    assign dec_out = OUT_ACTIVE_LOW ? ~hot_q : hot_q;

    assign D0 = dec_out[0];
    assign D1 = dec_out[1];
    assign D2 = dec_out[2];
    assign D3 = dec_out[3];
    assign D4 = dec_out[4];
    assign D5 = dec_out[5];
    assign D6 = dec_out[6];
    assign D7 = dec_out[7];
    assign D8 = dec_out[8];
    assign D9 = dec_out[9];

`ifdef DEC_BCD_TO_DEC_ERR_EN
    // Invalid-code flag, always active-high, same one-cycle latency as the decode lines.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else begin
            err <= invalid;
        end
    end
`else
    logic unused_invalid;
    assign unused_invalid = invalid;
`endif

endmodule

// File: tb/tb_dec_bcd_to_dec.sv
// Scoreboard bench for dec_bcd_to_dec: active-high and active-low instances
// share stimulus; expected responses are queued at each sampling edge and
// checked by an independent monitor shortly after the following falling edge.
module tb_dec_bcd_to_dec;
    import dec_bcd_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic E, A, B, C, D;

    logic h0, h1, h2, h3, h4, h5, h6, h7, h8, h9;
    logic l0, l1, l2, l3, l4, l5, l6, l7, l8, l9;
`ifdef DEC_BCD_TO_DEC_ERR_EN
    logic err_h, err_l;
`endif

    dec_hot_t hi_vec, lo_vec;
    assign hi_vec = {h9, h8, h7, h6, h5, h4, h3, h2, h1, h0};
    assign lo_vec = {l9, l8, l7, l6, l5, l4, l3, l2, l1, l0};

    typedef struct packed {
        dec_hot_t hot;
        logic     err;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dec_bcd_to_dec #(.OUT_ACTIVE_LOW(1'b0)) u_hi (
        .clk(clk), .rst(rst), .E(E), .A(A), .B(B), .C(C), .D(D),
        .D0(h0), .D1(h1), .D2(h2), .D3(h3), .D4(h4),
        .D5(h5), .D6(h6), .D7(h7), .D8(h8), .D9(h9)
`ifdef DEC_BCD_TO_DEC_ERR_EN
        , .err(err_h)
`endif
    );

    dec_bcd_to_dec #(.OUT_ACTIVE_LOW(1'b1)) u_lo (
        .clk(clk), .rst(rst), .E(E), .A(A), .B(B), .C(C), .D(D),
        .D0(l0), .D1(l1), .D2(l2), .D3(l3), .D4(l4),
        .D5(l5), .D6(l6), .D7(l7), .D8(l8), .D9(l9)
`ifdef DEC_BCD_TO_DEC_ERR_EN
        , .err(err_l)
`endif
    );

    task automatic check_vec(input string name, input dec_hot_t act, input dec_hot_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Both instances against one expectation: the active-low one must be the exact complement.
    task automatic check_all(input string name, input exp_t e);
        check_vec({name, "_hi"}, hi_vec, e.hot);
        check_vec({name, "_lo"}, lo_vec, ~e.hot);
`ifdef DEC_BCD_TO_DEC_ERR_EN
        check_bit({name, "_err_hi"}, err_h, e.err);
        check_bit({name, "_err_lo"}, err_l, e.err);
`endif
    endtask

    // Drive a vector away from the sampling edge, queue its expectation at the edge.
    task automatic apply(input logic e, input bcd_t code, input dec_hot_t exp_hot, input logic exp_err);
        exp_t x;
        @(negedge clk);
        E = e;
        {A, B, C, D} = code;
        @(posedge clk);
        x.hot = exp_hot;
        x.err = exp_err;
        q.push_back(x);
    endtask

    // Monitor: 1 ns after each falling edge, by which time the inputs already hold the next vector.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (q.size() > 0) begin
                mon_e = q.pop_front();
                check_all("dec", mon_e);
            end
        end
    end

    initial begin
        exp_t x;
        rst = 1'b1;
        E = 1'b0;
        {A, B, C, D} = 4'd0;

        // Power-on reset state before any clock edge
        #2;
        x.hot = '0;
        x.err = 1'b0;
        check_all("por", x);

        @(negedge clk);
        rst = 1'b0;

        // Hand-picked decodes
        apply(1'b1, 4'd7, 10'b00_1000_0000, 1'b0);
        apply(1'b1, 4'd0, 10'b00_0000_0001, 1'b0);
        apply(1'b1, 4'd9, 10'b10_0000_0000, 1'b0);
        apply(1'b1, 4'd4, 10'b00_0001_0000, 1'b0);

        // Enabled sweep 0..9
        for (int i = 0; i < 10; i++)
            apply(1'b1, bcd_t'(i), dec_hot_t'(1) << i, 1'b0);

        // Disabled sweep 0..9, including 1001
        for (int i = 0; i < 10; i++)
            apply(1'b0, bcd_t'(i), 10'b0, 1'b0);

        // Invalid codes while enabled
        apply(1'b1, 4'd10, 10'b0, 1'b1);
        apply(1'b1, 4'd11, 10'b0, 1'b1);
        apply(1'b1, 4'd12, 10'b0, 1'b1);
        apply(1'b1, 4'd13, 10'b0, 1'b1);
        apply(1'b1, 4'd14, 10'b0, 1'b1);
        apply(1'b1, 4'd15, 10'b0, 1'b1);
        // Invalid code while disabled: no err
        apply(1'b0, 4'd12, 10'b0, 1'b0);

        // Enable toggle with code 3 held
        apply(1'b0, 4'd3, 10'b0, 1'b0);
        apply(1'b1, 4'd3, 10'b00_0000_1000, 1'b0);
        apply(1'b0, 4'd3, 10'b0, 1'b0);

        // Mid-operation async reset while D5 is driven
        apply(1'b1, 4'd5, 10'b00_0010_0000, 1'b0);
        @(negedge clk);
        #2;
        x.hot = 10'b00_0010_0000;
        x.err = 1'b0;
        check_all("pre_rst", x);
        rst = 1'b1;
        #1;
        x.hot = '0;
        check_all("rst_async", x);
        rst = 1'b0;
        #1;
        check_all("rst_released", x);
        @(posedge clk);
        x.hot = 10'b00_0010_0000;
        q.push_back(x);

        // Back-to-back change after reset recovery
        apply(1'b1, 4'd8, 10'b01_0000_0000, 1'b0);

        // Drain with a bounded wait
        for (int n = 0; n < 10 && q.size() > 0; n++)
            @(negedge clk);
        #3;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
